// File: rtl/memory_arbiter_rv32_if.sv
// rtl/memory_arbiter_rv32_if.sv - requester/memory bus bundle for memory_arbiter_rv32
//
// Groups the fetch port, the load/store port and the memory port.
//   slave  : arbiter view (requests and memory completion in, grants/responses out)
//   master : environment view (fetch logic, execute stage and memory block)
//   enable            arbiter grant enable
//   fetch_*           instruction fetch request/response
//   data_*            load/store request/response
//   mem_*             registered memory access and its completion
//   bus_error, busy   response qualifier and activity flag
interface memory_arbiter_rv32_if;
    logic        enable;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic [31:0] fetch_instruction;
    logic        data_request;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_write_value;
    logic [3:0]  data_byte_enable;
    logic        data_ready;
    logic [31:0] data_read_value;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_value;
    logic [3:0]  mem_byte_enable;
    logic        mem_ready;
    logic [31:0] mem_read_value;
    logic        bus_error;
    logic        busy;

    modport slave (
        input  enable, fetch_request, fetch_address,
        input  data_request, data_write, data_address, data_write_value, data_byte_enable,
        input  mem_ready, mem_read_value,
        output fetch_ready, fetch_instruction, data_ready, data_read_value,
        output mem_request, mem_write, mem_address, mem_write_value, mem_byte_enable,
        output bus_error, busy
    );

    modport master (
        output enable, fetch_request, fetch_address,
        output data_request, data_write, data_address, data_write_value, data_byte_enable,
        output mem_ready, mem_read_value,
        input  fetch_ready, fetch_instruction, data_ready, data_read_value,
        input  mem_request, mem_write, mem_address, mem_write_value, mem_byte_enable,
        input  bus_error, busy
    );
endinterface

// File: rtl/memory_arbiter_rv32.sv
// rtl/memory_arbiter_rv32.sv - shares one memory port between fetch and load/store
//
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      memory_arbiter_rv32_if.slave (requests, responses, memory port)
// Data wins over fetch unless fetch has already lost FETCH_STARVE_LIMIT
// consecutive contested grants. One access at a time; a registered one-cycle
// ready pulse goes back to the winner.
module memory_arbiter_rv32 #(
    parameter int unsigned FETCH_STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    memory_arbiter_rv32_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, FETCH_ACCESS, DATA_ACCESS, RESPOND} state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(FETCH_STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  timer_q, timer_d;
    logic        mem_request_q, mem_request_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_write_value_q, mem_write_value_d;
    logic [3:0]  mem_byte_enable_q, mem_byte_enable_d;
    logic        fetch_ready_q, fetch_ready_d;
    logic [31:0] fetch_instruction_q, fetch_instruction_d;
    logic        data_ready_q, data_ready_d;
    logic [31:0] data_read_value_q, data_read_value_d;
    logic        bus_error_q, bus_error_d;
    logic        grant_data;
    logic        timed_out;

    always_comb begin
        state_d             = state_q;
        starve_d            = starve_q;
        timer_d             = timer_q;
        mem_request_d       = mem_request_q;
        mem_write_d         = mem_write_q;
        mem_address_d       = mem_address_q;
        mem_write_value_d   = mem_write_value_q;
        mem_byte_enable_d   = mem_byte_enable_q;
        fetch_ready_d       = 1'b0;
        fetch_instruction_d = 32'd0;
        data_ready_d        = 1'b0;
        data_read_value_d   = 32'd0;
        bus_error_d         = 1'b0;
        grant_data          = 1'b0;
        timed_out           = (TIMEOUT_CYCLES != 0) && (timer_q == TIMEOUT_LAST);

        unique case (state_q)
            IDLE: begin
                if (bus.enable && (bus.data_request || bus.fetch_request)) begin
                    // Fetch only wins a contested grant once it has been starved.
                    grant_data    = bus.data_request &&
                                    !(bus.fetch_request && (starve_q == STARVE_LIMIT));
                    mem_request_d = 1'b1;
                    timer_d       = 8'd0;
                    if (grant_data) begin
                        state_d           = DATA_ACCESS;
                        mem_write_d       = bus.data_write;
                        mem_address_d     = bus.data_address;
                        mem_write_value_d = bus.data_write_value;
                        mem_byte_enable_d = bus.data_write ? bus.data_byte_enable : 4'b0000;
                        if (!bus.fetch_request) begin
                            starve_d = 4'd0;
                        end else if (starve_q != STARVE_LIMIT) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        state_d           = FETCH_ACCESS;
                        mem_write_d       = 1'b0;
                        mem_address_d     = bus.fetch_address;
                        mem_write_value_d = 32'd0;
                        mem_byte_enable_d = 4'b0000;
                        starve_d          = 4'd0;
                    end
                end
            end
            FETCH_ACCESS, DATA_ACCESS: begin
                // A completion in the timeout cycle beats the abort.
                if (bus.mem_ready || timed_out) begin
                    state_d       = RESPOND;
                    mem_request_d = 1'b0;
                    bus_error_d   = !bus.mem_ready;
                    if (state_q == DATA_ACCESS) begin
                        data_ready_d      = 1'b1;
                        data_read_value_d = (bus.mem_ready && !mem_write_q) ? bus.mem_read_value : 32'd0;
                    end else begin
                        fetch_ready_d       = 1'b1;
                        fetch_instruction_d = bus.mem_ready ? bus.mem_read_value : 32'd0;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            starve_q            <= 4'd0;
            timer_q             <= 8'd0;
            mem_request_q       <= 1'b0;
            mem_write_q         <= 1'b0;
            mem_address_q       <= 32'd0;
            mem_write_value_q   <= 32'd0;
            mem_byte_enable_q   <= 4'b0000;
            fetch_ready_q       <= 1'b0;
            fetch_instruction_q <= 32'd0;
            data_ready_q        <= 1'b0;
            data_read_value_q   <= 32'd0;
            bus_error_q         <= 1'b0;
        end else begin
            state_q             <= state_d;
            starve_q            <= starve_d;
            timer_q             <= timer_d;
            mem_request_q       <= mem_request_d;
            mem_write_q         <= mem_write_d;
            mem_address_q       <= mem_address_d;
            mem_write_value_q   <= mem_write_value_d;
            mem_byte_enable_q   <= mem_byte_enable_d;
            fetch_ready_q       <= fetch_ready_d;
            fetch_instruction_q <= fetch_instruction_d;
            data_ready_q        <= data_ready_d;
            data_read_value_q   <= data_read_value_d;
            bus_error_q         <= bus_error_d;
        end
    end

    assign bus.mem_request       = mem_request_q;
    assign bus.mem_write         = mem_write_q;
    assign bus.mem_address       = mem_address_q;
    assign bus.mem_write_value   = mem_write_value_q;
    assign bus.mem_byte_enable   = mem_byte_enable_q;
    assign bus.fetch_ready       = fetch_ready_q;
    assign bus.fetch_instruction = fetch_instruction_q;
    assign bus.data_ready        = data_ready_q;
    assign bus.data_read_value   = data_read_value_q;
    assign bus.bus_error         = bus_error_q;
    assign bus.busy              = (state_q != IDLE);
endmodule

// File: doc/memory_arbiter_rv32.md
# memory_arbiter_rv32

- Shares the single memory port (the unified code/data RAM) between the instruction-fetch path and the load/store path of the rv32i core.
- Accepts one request at a time.
- Applies data-over-fetch priority with a starvation guard.
- Drives a request/ready handshake to memory and returns a one-cycle response pulse to the winning requester.
- Sits between the pc/fetch logic, the execute stage and the memory block.

## Interface
Parameters:
- FETCH_STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; 1..15
- TIMEOUT_CYCLES, 16, access-state cycles before abort; 0 disables timeout; max 255

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  0 blocks new grants; an in-flight access still completes
- fetch_request  in  1  fetch wants an instruction word
- fetch_address  in  32  fetch byte address
- fetch_ready  out  1  one-cycle response pulse to fetch
- fetch_instruction  out  32  read word, valid while fetch_ready=1
- data_request  in  1  load/store wants access
- data_write  in  1  1=store, 0=load
- data_address  in  32  data byte address
- data_write_value  in  32  store data
- data_byte_enable  in  4  store byte lanes
- data_ready  out  1  one-cycle response pulse to load/store
- data_read_value  out  32  load word, valid while data_ready=1
- mem_request  out  1  memory access in progress
- mem_write  out  1  registered copy of data_write (0 for fetch)
- mem_address  out  32  registered address
- mem_write_value  out  32  registered store data
- mem_byte_enable  out  4  registered lanes (0000 for fetch and loads)
- mem_ready  in  1  memory completes access this cycle
- mem_read_value  in  32  read data, valid with mem_ready
- bus_error  out  1  qualifies a ready pulse caused by timeout
- busy  out  1  state != IDLE

## Operation
States:
- IDLE
- FETCH_ACCESS
- DATA_ACCESS
- RESPOND

IDLE, enable=1:
- data_request only: go to DATA_ACCESS.
- fetch_request only: go to FETCH_ACCESS.
- Both requests: DATA_ACCESS, unless starve_count == FETCH_STARVE_LIMIT, then FETCH_ACCESS.
- On any grant, latch the winner's address, write, value and lanes into the mem_* registers and assert mem_request.

IDLE, enable=0: stay in IDLE.

starve_count:
- Increments on a data grant while fetch_request=1, saturating at the limit.
- Clears on any fetch grant, and on a data grant while fetch_request=0.

*_ACCESS:
- mem_* held stable.
- mem_ready=1 → RESPOND; latch mem_read_value into the winner's read output; drop mem_request.
- Timeout counter reaches TIMEOUT_CYCLES → RESPOND with bus_error=1 and read value 0.

RESPOND:
- Exactly one of fetch_ready / data_ready is 1; next state is IDLE.
- Requests are not sampled in RESPOND, so a requester still holding its request during its ready pulse is not double-granted.

Other rules:
- mem_ready is ignored outside *_ACCESS.
- Requesters hold their request and fields stable until their ready pulse; the arbiter samples them only at the grant.
- Stores return data_read_value=0.

## Timing
Reset (reset_n=0 at an edge) forces, after that edge:
- state IDLE
- starve_count 0, timeout counter 0
- all outputs 0: mem_*, *_ready, read values, bus_error, busy

Reset mid-access abandons the transaction with no ready pulse; a stale mem_ready after reset is ignored.

Cycle sequence:
- Request sampled at edge k → mem_request=1 after edge k.
- mem_ready sampled at edge m → *_ready=1 for cycle m..m+1 → IDLE after edge m+1; the earliest next grant is sampled at edge m+2.
- Minimum turnaround: mem_ready in the first access cycle gives 3 cycles from request sampling to IDLE.
- Timeout: mem_request stays high for exactly TIMEOUT_CYCLES cycles, then RESPOND.
- mem_ready arriving in the same cycle as the timeout takes precedence: normal response, bus_error=0.

## Test plan
- **Single fetch:** fetch_request=1 at 0x0000_0010; memory answers mem_ready=1 one cycle later with 0x00500093 → mem_address=0x10, mem_write=0; fetch_ready pulses one cycle with fetch_instruction=0x00500093; data_ready stays 0.
- **Store:** data_request with data_write=1, data_address=0x100, data_write_value=0xDEADBEEF, data_byte_enable=0xF → mem_* carry exactly these values; data_ready pulses once with data_read_value=0.
- **Starvation guard:** both requests held continuously, FETCH_STARVE_LIMIT=4, memory replies instantly → grant order D,D,D,D,F,D,D,D,D,F.
- **Timeout:** TIMEOUT_CYCLES=16, mem_ready never asserted → mem_request high for 16 cycles; then data_ready=1 with bus_error=1 and data_read_value=0; state returns to IDLE.
- **Reset mid-access:** reset_n=0 for one edge during DATA_ACCESS, then mem_ready=1 → no ready pulse; all outputs 0; state IDLE.
- **Enable gating:** enable=0 with fetch_request=1 → no mem_request for 10 cycles. Raise enable → grant sampled at the next edge.
